// File: rtl/divider_8by4.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per cycle.
// Uses a start/busy/done handshake so it can share a sequencer with the 4x4 multiplier.
module divider_8by4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       divByZero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0] stateReg;
  logic [7:0] qReg;
  logic [3:0] dReg;
  logic [3:0] rReg;
  logic [2:0] cntReg;

  logic [4:0] trial;
  logic       fits;
  logic [3:0] rNext;
  logic [7:0] qNext;
  logic       accept;

  // The partial remainder always ends a step below the divisor, so 4 stored bits suffice.
  always_comb begin
    trial  = {rReg, qReg[7]};
    fits   = (trial >= {1'b0, dReg});
    rNext  = fits ? 4'(trial - {1'b0, dReg}) : trial[3:0];
    qNext  = {qReg[6:0], fits};
    accept = start && (stateReg != CALC);
  end

  assign busy = (stateReg == CALC);
  assign done = (stateReg == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg  <= IDLE;
      qReg      <= 8'h00;
      dReg      <= 4'h0;
      rReg      <= 4'h0;
      cntReg    <= 3'd0;
      quotient  <= 8'h00;
      remainder <= 4'h0;
      divByZero <= 1'b0;
    end else begin
      case (stateReg)
        CALC: begin
          rReg   <= rNext;
          qReg   <= qNext;
          cntReg <= cntReg - 3'd1;
          if (cntReg == 3'd0) begin
            stateReg  <= DONE;
            quotient  <= qNext;
            remainder <= rNext;
          end
        end
        default: begin
          if (accept) begin
            if (divisor == 4'h0) begin
              // Zero divisor short-circuits straight to DONE with a saturated quotient.
              stateReg  <= DONE;
              quotient  <= 8'hFF;
              remainder <= 4'h0;
              divByZero <= 1'b1;
            end else begin
              stateReg  <= CALC;
              qReg      <= dividend;
              dReg      <= divisor;
              rReg      <= 4'h0;
              cntReg    <= 3'd7;
              divByZero <= 1'b0;
            end
          end else begin
            stateReg <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
